// File: rtl/decade_step_ctrl_pkg.sv
// decade_ctrl_pkg: shared types, constants and helpers for the decade step controller
//  state_t    controller FSM states
//  DIR_UP/DIR_DOWN, DIGIT_MAX, sat_digit() clamps a preload value into 0..9
package decade_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  function automatic logic [3:0] sat_digit(input logic [3:0] v);
    return v > DIGIT_MAX ? DIGIT_MAX : v;
  endfunction
endpackage

// File: rtl/decade_step_ctrl_if.sv
// decade_step_ctrl_if: command valid/ready channel between host and decade_step_ctrl
//  cmd_valid/cmd_ready handshake, cmd_dir (0 up, 1 down), cmd_steps, cmd_load, cmd_load_val
//  master = host side, slave = controller side
interface decade_step_ctrl_if #(parameter int STEP_W = 8);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic cmd_load;
  logic [3:0] cmd_load_val;
  modport master(output cmd_valid, cmd_dir, cmd_steps, cmd_load, cmd_load_val, input cmd_ready);
  modport slave(input cmd_valid, cmd_dir, cmd_steps, cmd_load, cmd_load_val, output cmd_ready);
endinterface

// File: rtl/mod10_updown_cell.sv
// mod10_updown_cell: mod-10 up/down digit register with preload and wrap carry
//  clk, reset (async, active-high); en steps once, dir 0 up / 1 down
//  load/load_val preload the digit (load_val already saturated); q digit, c one-cycle wrap pulse
module mod10_updown_cell
  import decade_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       c
);
  logic wrap;
  assign wrap = dir == DIR_DOWN ? q == 4'd0 : q == DIGIT_MAX;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= 4'd0;
      c <= 1'b0;
    end else begin
      c <= en & wrap;
      if (load) q <= load_val;
      else if (en) q <= dir == DIR_DOWN ? (wrap ? DIGIT_MAX : q - 4'd1) : (wrap ? 4'd0 : q + 4'd1);
    end
endmodule

// File: rtl/decade_step_ctrl.sv
// decade_step_ctrl: command-driven sequencer stepping a mod-10 up/down digit at a programmable rate
//  clk, reset (async, active-high); cmd = command channel (slave modport, cmd_ready decoded from state)
//  pause/abort levels; q digit, c wrap pulse, busy in RUN/PAUSE, done one-cycle completion pulse
//  wrap_cnt (8-bit wrap counter) present only when DECADE_WRAP_CNT_EN is defined
module decade_step_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  decade_step_ctrl_if.slave   cmd,
  input  logic                pause,
  input  logic                abort,
  output logic [3:0]          q,
  output logic                c,
  output logic                busy,
  output logic                done
`ifdef DECADE_WRAP_CNT_EN
  ,
  output logic [7:0]          wrap_cnt
`endif
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state;
  logic [PW-1:0] presc;
  logic [STEP_W-1:0] remaining;
  logic dir_r, accept, active, tick;
  assign cmd.cmd_ready = state == IDLE;
  assign accept = state == IDLE && cmd.cmd_valid;
  // abort outranks pause, which outranks the prescaler; leaving PAUSE counts on the same edge
  assign active = (state == RUN || state == PAUSE) && !abort && !pause;
  assign tick = active && presc == PW'(TICK_DIV - 1);
  mod10_updown_cell u_cell (
    .clk(clk),
    .reset(reset),
    .en(tick),
    .dir(dir_r),
    .load(accept && cmd.cmd_load),
    .load_val(sat_digit(cmd.cmd_load_val)),
    .q(q),
    .c(c)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      remaining <= '0;
      dir_r <= DIR_UP;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE:
          if (cmd.cmd_valid) begin
            dir_r <= cmd.cmd_dir;
            remaining <= cmd.cmd_steps;
            presc <= '0;
            state <= cmd.cmd_steps == '0 ? DONE : RUN;
            busy <= cmd.cmd_steps != '0;
            done <= cmd.cmd_steps == '0;
          end
        RUN, PAUSE:
          if (abort) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (pause) state <= PAUSE;
          else if (tick) begin
            presc <= '0;
            remaining <= remaining - STEP_W'(1);
            state <= remaining == STEP_W'(1) ? DONE : RUN;
            busy <= remaining != STEP_W'(1);
            done <= remaining == STEP_W'(1);
          end else begin
            presc <= presc + PW'(1);
            state <= RUN;
          end
        DONE: state <= IDLE;
      endcase
    end
`ifdef DECADE_WRAP_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) wrap_cnt <= 8'd0;
    else if (c) wrap_cnt <= wrap_cnt + 8'd1;
`endif
endmodule
